mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Multiply uses a shift-add loop and divide uses restoring division. Both work on
// operand magnitudes and fix up the sign in a final cycle, so every operation
// takes a fixed 32 iteration cycles plus one finish cycle.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        HiWrite,
    input  logic        LoWrite,
    input  logic [31:0] WriteData,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;    // quotient/product must be negated
    logic        neg_rem_q, neg_rem_d;    // remainder takes the dividend's sign
    logic        div_zero_q, div_zero_d;
    logic [31:0] src_a_q, src_a_d;        // raw dividend, returned in Hi on divide by zero
    logic [31:0] operand_q, operand_d;    // multiplicand or divisor magnitude
    logic [63:0] acc_q, acc_d;            // {partial high, multiplier} or {remainder, quotient}
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // Operand magnitudes formed from the live inputs at the start edge.
    logic        signed_op;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    // One iteration step of each algorithm, plus the final sign fix-up values.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] div_next;
    logic [63:0] prod_neg;
    logic [31:0] quo_neg, rem_neg;

    // Operand sign detection and magnitude formation
    always_comb begin
        signed_op = ~Op[0];
        a_neg     = signed_op & SrcA[31];
        b_neg     = signed_op & SrcB[31];
        a_mag     = a_neg ? (32'd0 - SrcA) : SrcA;
        b_mag     = b_neg ? (32'd0 - SrcB) : SrcB;
    end

    // Datapath for a single shift-add / restoring-subtract step and the fix-up
    always_comb begin
        // Add the multiplicand when the current multiplier bit is set, then shift right.
        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? operand_q : 32'd0)};
        mul_next = {mul_sum, acc_q[31:1]};

        // Shift the next dividend bit into the remainder and try to subtract.
        // When the trial fits, the difference is below 2^32, so 32-bit wrap is exact.
        div_trial = {acc_q[63:32], acc_q[31]};
        div_ge    = div_trial >= {1'b0, operand_q};
        div_sub   = div_trial[31:0] - operand_q;
        div_next  = {(div_ge ? div_sub : div_trial[31:0]), acc_q[30:0], div_ge};

        prod_neg = 64'd0 - acc_q;
        quo_neg  = 32'd0 - acc_q[31:0];
        rem_neg  = 32'd0 - acc_q[63:32];
    end

    // Next-state logic for the control FSM and all datapath registers
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        src_a_d    = src_a_q;
        operand_d  = operand_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (HiWrite) begin
                    hi_d = WriteData;
                end
                if (LoWrite) begin
                    lo_d = WriteData;
                end
                if (Start) begin
                    is_div_d   = Op[1];
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = (SrcB == 32'd0);
                    src_a_d    = SrcA;
                    count_d    = 5'd0;
                    if (Op[1]) begin
                        operand_d = b_mag;
                        acc_d     = {32'd0, a_mag};
                    end else begin
                        operand_d = a_mag;
                        acc_d     = {32'd0, b_mag};
                    end
                    state_d = StCalc;
                end
            end
            StCalc: begin
                acc_d   = is_div_q ? div_next : mul_next;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (!is_div_q) begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
                end else if (div_zero_q) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = src_a_q;
                end else begin
                    lo_d = neg_res_q ? quo_neg : acc_q[31:0];
                    hi_d = neg_rem_q ? rem_neg : acc_q[63:32];
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= 5'd0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            src_a_q    <= 32'd0;
            operand_q  <= 32'd0;
            acc_q      <= 64'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            src_a_q    <= src_a_d;
            operand_q  <= operand_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    // Output drive
    always_comb begin
        Hi   = hi_q;
        Lo   = lo_q;
        Busy = (state_q != StIdle);
        Done = done_q;
    end

endmodule
